// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg
//   Shared constants and types for the approximate-adder scheduler.
//   WIDTH_DEF / K_APPROX_DEF : default operand width and approximate cut.
//   ID_MAX_W                 : id field width, enough for up to 8 requesters.
//   ID_W()                   : requester-index width for a given count.
//   state_t                  : scheduler FSM states.
//   req_t                    : captured request (operands sized to WIDTH_DEF).
package approx_adder_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int K_APPROX_DEF = 6;
  localparam int ID_MAX_W     = 3;

  // Index width never drops below 1 so a port of this width always exists.
  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic                 cin;
    logic                 exact;
    logic [ID_MAX_W-1:0]  id;
  } req_t;

endpackage

// File: rtl/approx_sklansky_core.sv
// approx_sklansky_core
//   Combinational Sklansky parallel-prefix adder with an optional carry cut.
//   a, b  : operands            cin   : carry-in (honoured in exact mode only)
//   exact : 1 = exact add, 0 = low K bits generate-only, no carry-in
//   sum   : result              cout  : carry out of the MSB
module approx_sklansky_core #(
  parameter int WIDTH = 16,
  parameter int K     = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             exact,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_lvl0;
  logic [WIDTH-1:0] p_lvl0;
  logic [WIDTH-1:0] g_fin;
  logic             cin_eff;

  assign p       = a ^ b;
  assign cin_eff = exact & cin;

  // Approximation is expressed as a killed propagate in the low K bits:
  // a bit that cannot propagate makes its carry equal its own generate.
  // The carry-in is folded into bit 0's generate so the prefix tree alone
  // yields every carry.
  genvar gi, gl;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_init
      if (gi < K) begin : g_cut
        assign p_lvl0[gi] = p[gi] & exact;
      end else begin : g_full
        assign p_lvl0[gi] = p[gi];
      end
      if (gi == 0) begin : g_cin
        assign g_lvl0[gi] = (a[gi] & b[gi]) | (p_lvl0[gi] & cin_eff);
      end else begin : g_gen
        assign g_lvl0[gi] = a[gi] & b[gi];
      end
    end

    // Level gl: every node with bit gl set merges with the last node of the
    // preceding aligned 2^gl block. The last level needs no propagate output.
    for (gl = 0; gl < LEVELS; gl++) begin : g_stage
      logic [WIDTH-1:0] g_prev;
      logic [WIDTH-1:0] p_prev;
      logic [WIDTH-1:0] g_cur;

      if (gl == 0) begin : g_src0
        assign g_prev = g_lvl0;
        assign p_prev = p_lvl0;
      end else begin : g_srcn
        assign g_prev = g_stage[gl-1].g_cur;
        assign p_prev = g_stage[gl-1].g_pn.p_cur;
      end

      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (((gi >> gl) % 2) == 1) begin : g_merge
          localparam int PART = ((gi >> gl) << gl) - 1;
          assign g_cur[gi] = g_prev[gi] | (p_prev[gi] & g_prev[PART]);
        end else begin : g_pass
          assign g_cur[gi] = g_prev[gi];
        end
      end

      if (gl < LEVELS - 1) begin : g_pn
        logic [WIDTH-1:0] p_cur;
        for (gi = 0; gi < WIDTH; gi++) begin : g_pbit
          if (((gi >> gl) % 2) == 1) begin : g_merge
            localparam int PART = ((gi >> gl) << gl) - 1;
            assign p_cur[gi] = p_prev[gi] & p_prev[PART];
          end else begin : g_pass
            assign p_cur[gi] = p_prev[gi];
          end
        end
      end
    end

    // g_fin[i] is the carry out of bit i, i.e. the carry into bit i+1.
    assign g_fin = g_stage[LEVELS-1].g_cur;

    for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      if (gi == 0) begin : g_lsb
        assign sum[gi] = p[gi] ^ cin_eff;
      end else begin : g_rest
        assign sum[gi] = p[gi] ^ g_fin[gi-1];
      end
    end
  endgenerate

  assign cout = g_fin[WIDTH-1];

endmodule

// File: rtl/approx_adder_scheduler.sv
// approx_adder_scheduler
//   Round-robin scheduler sharing one approximate adder among NUM_REQ users.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin, req_exact  : per-requester carry-in and mode
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/sum/cout/exact : registered result, stable while stalled
//   cnt_approx/cnt_exact  : saturating completed-operation counters
module approx_adder_scheduler
  import approx_adder_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int K_APPROX = K_APPROX_DEF,
  localparam int IDW      = ID_W(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  input  logic [NUM_REQ-1:0]       req_exact,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_exact,
  output logic [15:0]              cnt_approx,
  output logic [15:0]              cnt_exact
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  req_t             cap_q, cap_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_exact_q, rsp_exact_d;
  logic [15:0]      cnt_approx_q, cnt_approx_d;
  logic [15:0]      cnt_exact_q, cnt_exact_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   scan_idx;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout;

  approx_sklansky_core #(
    .WIDTH (WIDTH),
    .K     (K_APPROX)
  ) u_core (
    .a     (cap_q.a),
    .b     (cap_q.b),
    .cin   (cap_q.cin),
    .exact (cap_q.exact),
    .sum   (core_sum),
    .cout  (core_cout)
  );

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(rr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      cap_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_exact_q  <= 1'b0;
      cnt_approx_q <= '0;
      cnt_exact_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      cap_q        <= cap_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_exact_q  <= rsp_exact_d;
      cnt_approx_q <= cnt_approx_d;
      cnt_exact_q  <= cnt_exact_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cap_d        = cap_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_exact_d  = rsp_exact_q;
    cnt_approx_d = cnt_approx_q;
    cnt_exact_d  = cnt_exact_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cap_d.a     = req_a[grant_idx*WIDTH +: WIDTH];
          cap_d.b     = req_b[grant_idx*WIDTH +: WIDTH];
          cap_d.cin   = req_cin[grant_idx];
          cap_d.exact = req_exact[grant_idx];
          cap_d.id    = ID_MAX_W'(grant_idx);
          state_d     = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = core_sum;
        rsp_cout_d  = core_cout;
        rsp_exact_d = cap_q.exact;
        rsp_id_d    = IDW'(cap_q.id);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_exact_q) begin
            if (cnt_exact_q != 16'hFFFF) cnt_exact_d = cnt_exact_q + 16'd1;
          end else begin
            if (cnt_approx_q != 16'hFFFF) cnt_approx_d = cnt_approx_q + 16'd1;
          end
          rr_d    = (rsp_id_q == IDW'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is visible only while idle and out of reset; reset is asynchronous,
  // so it also masks the combinational ready.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_exact  = rsp_exact_q;
  assign cnt_approx = cnt_approx_q;
  assign cnt_exact  = cnt_exact_q;

endmodule

// File: tb/tb_approx_adder_scheduler.sv
// tb_approx_adder_scheduler
//   Directed-vector bench for approx_adder_scheduler (NUM_REQ=4, WIDTH=16,
//   K_APPROX=6). Each scenario task drives stimulus and checks inline.
module tb_approx_adder_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [NUM_REQ-1:0]       req_exact;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     rsp_exact;
  logic [15:0]              cnt_approx;
  logic [15:0]              cnt_exact;

  int total_cnt = 0;
  int pass_cnt  = 0;

  approx_adder_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .K_APPROX (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_exact  (req_exact),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_exact  (rsp_exact),
    .cnt_approx (cnt_approx),
    .cnt_exact  (cnt_exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request, wait for its grant and its result (both bounded).
  // Returns the result fields and grant-to-valid latency in cycles.
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic ex,
                       output logic [15:0] s, output logic co, output logic e_o,
                       output logic [1:0] rid, output int lat);
    int n;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_cin[id]   = cin;
    req_exact[id] = ex;
    req_valid[id] = 1'b1;
    n = 0;
    #1;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    #1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    if (n >= 20) lat = 99;
    s = rsp_sum; co = rsp_cout; e_o = rsp_exact; rid = rsp_id;
    $display("txn id=%0d a=%h b=%h cin=%0b exact=%0b -> sum=%h cout=%0b rsp_id=%0d lat=%0d",
             id, a, b, cin, ex, s, co, rid, lat);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_exact, cnt_approx, cnt_exact} !== '0)
      $display("FAIL reset_state: got ready=%b valid=%b id=%0d sum=%h cout=%b ex=%b ca=%0d ce=%0d, want all zero",
               req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_exact, cnt_approx, cnt_exact);
    else pass_cnt++;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_approx();
    logic [15:0] s; logic co, e; logic [1:0] rid; int lat;
    issue(0, 16'h003F, 16'h0001, 1'b0, 1'b0, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co, e, rid} !== {16'h003C, 1'b0, 1'b0, 2'd0})
      $display("FAIL approx_3f_1: got sum=%h cout=%b ex=%b id=%0d, want 003c 0 0 0", s, co, e, rid);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL latency: got %0d cycles, want 2", lat);
    else pass_cnt++;
    accept();
    total_cnt++;
    if ({cnt_approx, cnt_exact, rsp_valid} !== {16'd1, 16'd0, 1'b0})
      $display("FAIL cnt_after_approx: got ca=%0d ce=%0d valid=%b, want 1 0 0", cnt_approx, cnt_exact, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_exact();
    logic [15:0] s; logic co, e; logic [1:0] rid; int lat;
    issue(1, 16'h003F, 16'h0001, 1'b0, 1'b1, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co, e, rid} !== {16'h0040, 1'b0, 1'b1, 2'd1})
      $display("FAIL exact_3f_1: got sum=%h cout=%b ex=%b id=%0d, want 0040 0 1 1", s, co, e, rid);
    else pass_cnt++;
    accept();
    issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co, rid} !== {16'h0000, 1'b1, 2'd2})
      $display("FAIL exact_ffff_1: got sum=%h cout=%b id=%0d, want 0000 1 2", s, co, rid);
    else pass_cnt++;
    accept();
    issue(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co, e} !== {16'hFFFC, 1'b0, 1'b0})
      $display("FAIL approx_ffff_1: got sum=%h cout=%b ex=%b, want fffc 0 0", s, co, e);
    else pass_cnt++;
    accept();
    issue(0, 16'h1234, 16'h0001, 1'b1, 1'b1, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co} !== {16'h1236, 1'b0})
      $display("FAIL exact_cin: got sum=%h cout=%b, want 1236 0", s, co);
    else pass_cnt++;
    accept();
    total_cnt++;
    if ({cnt_approx, cnt_exact} !== {16'd2, 16'd3})
      $display("FAIL cnt_after_exact: got ca=%0d ce=%0d, want 2 3", cnt_approx, cnt_exact);
    else pass_cnt++;
  endtask

  task automatic test_upper();
    logic [15:0] s; logic co, e; logic [1:0] rid; int lat;
    issue(1, 16'h00C0, 16'h0040, 1'b0, 1'b0, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co} !== {16'h0100, 1'b0})
      $display("FAIL approx_upper_prop: got sum=%h cout=%b, want 0100 0", s, co);
    else pass_cnt++;
    accept();
    issue(2, 16'h0000, 16'h0000, 1'b1, 1'b0, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co} !== {16'h0000, 1'b0})
      $display("FAIL approx_cin_ignored: got sum=%h cout=%b, want 0000 0", s, co);
    else pass_cnt++;
    accept();
  endtask

  task automatic test_backpressure();
    logic [15:0] s; logic co, e; logic [1:0] rid; int lat;
    logic [15:0] ce0;
    issue(2, 16'h0101, 16'h0202, 1'b0, 1'b1, s, co, e, rid, lat);
    total_cnt++;
    if ({s, co, e, rid} !== {16'h0303, 1'b0, 1'b1, 2'd2})
      $display("FAIL bp_result: got sum=%h cout=%b ex=%b id=%0d, want 0303 0 1 2", s, co, e, rid);
    else pass_cnt++;
    ce0 = cnt_exact;
    req_valid = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({rsp_valid, rsp_sum, rsp_cout, rsp_exact, rsp_id, req_ready, cnt_exact} !==
          {1'b1, 16'h0303, 1'b0, 1'b1, 2'd2, 4'b0000, ce0})
        $display("FAIL bp_hold_cycle%0d: got valid=%b sum=%h id=%0d ready=%b ce=%0d, want 1 0303 2 0000 %0d",
                 c, rsp_valid, rsp_sum, rsp_id, req_ready, cnt_exact, ce0);
      else pass_cnt++;
    end
    req_valid = '0;
    accept();
    total_cnt++;
    if ({rsp_valid, cnt_exact} !== {1'b0, ce0 + 16'd1})
      $display("FAIL bp_release: got valid=%b ce=%0d, want 0 %0d", rsp_valid, cnt_exact, ce0 + 16'd1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic co, e; logic [1:0] rid; int lat;
    issue(1, 16'h0011, 16'h0022, 1'b0, 1'b0, s, co, e, rid, lat);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({rsp_valid, cnt_approx, cnt_exact} !== {1'b0, 16'd0, 16'd0})
      $display("FAIL reset_mid_async: got valid=%b ca=%0d ce=%0d, want 0 0 0", rsp_valid, cnt_approx, cnt_exact);
    else pass_cnt++;
    @(negedge clk);
    req_a[0 +: WIDTH] = 16'h0005;
    req_b[0 +: WIDTH] = 16'h0003;
    req_cin[0] = 1'b0;
    req_exact[0] = 1'b1;
    req_valid = 4'b1001;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0001)
      $display("FAIL reset_mid_grant: got ready=%b, want 0001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++;
    if (rsp_valid !== 1'b0)
      $display("FAIL reset_mid_no_stale: got valid=%b, want 0", rsp_valid);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_exact} !== {1'b1, 2'd0, 16'h0008, 1'b1})
      $display("FAIL reset_mid_result: got valid=%b id=%0d sum=%h ex=%b, want 1 0 0008 1",
               rsp_valid, rsp_id, rsp_sum, rsp_exact);
    else pass_cnt++;
    accept();
  endtask

  task automatic test_round_robin();
    int g_ids[$];
    int g_cyc[$];
    int r_ids[$];
    logic [15:0] r_sum[$];
    int bad1h;
    int exp_rr[5];
    logic [15:0] exp_s;
    exp_rr = '{0, 1, 2, 3, 0};
    bad1h = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 16'(i * 16'h1111);
      req_b[i*WIDTH +: WIDTH] = 16'h0001;
      req_cin[i] = 1'b0;
      req_exact[i] = 1'b1;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 17; cyc++) begin
      #1;
      if ($countones(req_ready) > 1) bad1h++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] === 1'b1) begin
          g_ids.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (rsp_valid === 1'b1) begin
        r_ids.push_back(int'(rsp_id));
        r_sum.push_back(rsp_sum);
      end
      @(negedge clk);
    end
    req_valid = '0;
    total_cnt++;
    if (bad1h !== 0) $display("FAIL rr_onehot: got %0d multi-hot cycles, want 0", bad1h);
    else pass_cnt++;
    total_cnt++;
    if (g_ids.size() < 5 || r_ids.size() < 5)
      $display("FAIL rr_count: got %0d grants %0d responses, want at least 5 each", g_ids.size(), r_ids.size());
    else begin
      pass_cnt++;
      for (int k = 0; k < 5; k++) begin
        total_cnt++;
        if (g_ids[k] !== exp_rr[k] || r_ids[k] !== exp_rr[k])
          $display("FAIL rr_order%0d: got grant=%0d rsp_id=%0d, want %0d", k, g_ids[k], r_ids[k], exp_rr[k]);
        else pass_cnt++;
        total_cnt++;
        if (g_cyc[k] !== 3 * k)
          $display("FAIL rr_spacing%0d: got cycle %0d, want %0d", k, g_cyc[k], 3 * k);
        else pass_cnt++;
        exp_s = 16'(exp_rr[k] * 16'h1111) + 16'h0001;
        total_cnt++;
        if (r_sum[k] !== exp_s)
          $display("FAIL rr_sum%0d: got %h, want %h", k, r_sum[k], exp_s);
        else pass_cnt++;
      end
    end
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_exact = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_approx();
    test_exact();
    test_upper();
    test_backpressure();
    test_reset_mid();
    test_round_robin();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
